// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg -- shared definitions for the multi-cycle data-memory responder.
//   DMEM_DEF_DEPTH / DMEM_DEF_LATENCY : default geometry and wait count
//   dmem_state_e                      : FSM state encoding (IDLE/WAIT/DONE)
//   dmem_req_t                        : request captured on the accept edge
// Configuration macro: DMEM_BYTE_WRITE_EN (adds per-byte store enables).
package dmem_responder_pkg;

   localparam int DMEM_DEF_DEPTH   = 64;
   localparam int DMEM_DEF_LATENCY = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } dmem_state_e;

   typedef struct packed {
      logic        we;
      logic [31:0] a;
      logic [31:0] wd;
      logic [3:0]  be;
   } dmem_req_t;

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if -- core <-> data-memory port.
//   req/we/a/wd (+be) : request from the MEM stage (master drives)
//   rd/ack/stall      : response and hold-off from the memory (slave drives)
// Configuration macro: DMEM_BYTE_WRITE_EN adds be[3:0].
interface dmem_responder_if;

   logic        req;
   logic        we;
   logic [31:0] a;
   logic [31:0] wd;
`ifdef DMEM_BYTE_WRITE_EN
   logic [3:0]  be;
`endif
   logic [31:0] rd;
   logic        ack;
   logic        stall;

`ifdef DMEM_BYTE_WRITE_EN
   modport master (output req, we, a, wd, be, input  rd, ack, stall);
   modport slave  (input  req, we, a, wd, be, output rd, ack, stall);
`else
   modport master (output req, we, a, wd, input  rd, ack, stall);
   modport slave  (input  req, we, a, wd, output rd, ack, stall);
`endif

endinterface

// File: rtl/dmem_array.sv
// dmem_array -- DEPTH x 32 RAM, synchronous byte-lane write, synchronous read.
//   clk, reset : clock; async active-high reset (clears only the read register)
//   en         : single access strobe from the responder FSM
//   we         : 1 = write the enabled bytes, 0 = load into q
//   addr       : word index
//   wd, be     : write data and byte enables
//   q          : registered read data; holds its value except on a load
module dmem_array #(
   parameter int DEPTH = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wd,
   input  logic [3:0]    be,
   output logic [31:0]   q
);

   // Storage is deliberately not reset.
   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en && we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[addr][8*i +: 8] <= wd[8*i +: 8];
         end
      end
   end

   // q is the core-visible rd: zero after reset, only a load moves it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)         q <= '0;
      else if (en && !we) q <= mem[addr];
   end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder -- responder end of the core's data-memory port.
// Holds the core with stall for LATENCY cycles after accepting a request,
// then performs the access and pulses ack for one cycle.
//   clk, reset : clock; async active-high reset
//   bus        : dmem_responder_if.slave (req/we/a/wd[/be] in, rd/ack/stall out)
// Parameters: DEPTH (words, power of two >= 4), LATENCY (wait cycles >= 1).
// Configuration macro: DMEM_BYTE_WRITE_EN -- when defined, stores honour bus.be;
// otherwise every store writes the full word.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int DEPTH   = DMEM_DEF_DEPTH,
   parameter int LATENCY = DMEM_DEF_LATENCY
) (
   input  logic             clk,
   input  logic             reset,
   dmem_responder_if.slave  bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(LATENCY + 1);

   dmem_state_e   state, state_nxt;
   logic [CW-1:0] cnt;
   dmem_req_t     req_q;
   logic          commit;
   logic          ack_q;
   logic [31:0]   rd_q;
   logic [3:0]    be_in;

`ifdef DMEM_BYTE_WRITE_EN
   assign be_in = bus.be;
`else
   assign be_in = 4'hF;
`endif

   // Address bits outside the word index are ignored (aliasing is intended).
   logic unused_abits;
   assign unused_abits = ^{req_q.a[31:AW+2], req_q.a[1:0]};

   // Next state and stall. commit is derived from state, so an async reset
   // in WAIT kills the pending access before its edge.
   always_comb begin
      state_nxt = state;
      bus.stall = 1'b0;
      commit    = 1'b0;
      case (state)
         IDLE: begin
            bus.stall = bus.req;
            if (bus.req) state_nxt = WAIT;
         end
         WAIT: begin
            bus.stall = 1'b1;
            if (cnt == '0) begin
               commit    = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         req_q <= '0;
         ack_q <= 1'b0;
      end else begin
         state <= state_nxt;
         ack_q <= commit;
         // Capture only in IDLE; a req seen in DONE must be re-presented.
         if (state == IDLE && bus.req) begin
            req_q <= '{we: bus.we, a: bus.a, wd: bus.wd, be: be_in};
            cnt   <= CW'(LATENCY - 1);
         end else if (state == WAIT && cnt != '0) begin
            cnt <= cnt - 1'b1;
         end
      end
   end

   dmem_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk   (clk),
      .reset (reset),
      .en    (commit),
      .we    (req_q.we),
      .addr  (req_q.a[AW+1:2]),
      .wd    (req_q.wd),
      .be    (req_q.be),
      .q     (rd_q)
   );

   assign bus.rd  = rd_q;
   assign bus.ack = ack_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

   localparam int DEPTH = 64;
   localparam int LAT   = 2;
`ifdef DMEM_BYTE_WRITE_EN
   localparam bit BYTE_EN = 1'b1;
`else
   localparam bit BYTE_EN = 1'b0;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   dmem_responder_if bus();

   dmem_responder #(
      .DEPTH   (DEPTH),
      .LATENCY (LAT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: plain word array plus the last value a load returned.
   logic [31:0] mem_m [DEPTH];
   logic [31:0] last_rd;

   typedef struct {
      logic        we;
      logic [31:0] a;
      logic [31:0] wd;
      logic [3:0]  be;
      logic [31:0] exp;
   } vec_t;
   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int widx(input logic [31:0] addr);
      return int'((addr / 32'd4) % DEPTH);
   endfunction

   task automatic scramble();
      bus.we = 1'($urandom);
      bus.a  = $urandom;
      bus.wd = $urandom;
`ifdef DMEM_BYTE_WRITE_EN
      bus.be = 4'($urandom);
`endif
   endtask

   // One full transaction starting #1 after a posedge. Checks stall/ack on
   // every cycle and rd in the ack cycle; leaves time #1 after the posedge
   // that opens the next IDLE cycle.
   task automatic do_op(input logic w, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] be_in, input bit hold_done,
                        input bit has_exp, input logic [31:0] exp);
      logic [3:0]  be_eff;
      logic [31:0] mask, want;
      int          k;
      be_eff = BYTE_EN ? be_in : 4'hF;
      k      = widx(addr);
      want   = w ? last_rd : mem_m[k];
      bus.req = 1'b1; bus.we = w; bus.a = addr; bus.wd = data;
`ifdef DMEM_BYTE_WRITE_EN
      bus.be = be_in;
`endif
      for (int c = 0; c <= LAT + 1; c++) begin
         @(negedge clk);
         chk("stall", {31'b0, bus.stall}, {31'b0, (c <= LAT)});
         chk("ack",   {31'b0, bus.ack},   {31'b0, (c == LAT + 1)});
         if (c == LAT + 1) begin
            if (w) chk("rd_hold_on_store", bus.rd, want);
            else   chk("rd_load", bus.rd, want);
            if (has_exp) chk("rd_table", bus.rd, exp);
         end
         @(posedge clk); #1;
         if (c < LAT)       scramble();          // WAIT: inputs must be ignored
         else if (c == LAT) bus.req = hold_done; // DONE: req must not be captured
         else               bus.req = 1'b0;
      end
      if (hold_done) begin
         @(negedge clk);
         chk("idle_after_done_stall", {31'b0, bus.stall}, 32'd0);
         chk("idle_after_done_ack",   {31'b0, bus.ack},   32'd0);
         @(posedge clk); #1;
      end
      if (w) begin
         mask = {{8{be_eff[3]}}, {8{be_eff[2]}}, {8{be_eff[1]}}, {8{be_eff[0]}}};
         mem_m[k] = (mem_m[k] & ~mask) | (data & mask);
      end else begin
         last_rd = mem_m[k];
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      bus.req = 1'b0; bus.we = 1'b0; bus.a = '0; bus.wd = '0;
`ifdef DMEM_BYTE_WRITE_EN
      bus.be = 4'h0;
`endif
      last_rd = '0;

      // Reset state, then idle with req=0
      @(negedge clk);
      chk("reset_rd",    bus.rd, 32'd0);
      chk("reset_ack",   {31'b0, bus.ack},   32'd0);
      chk("reset_stall", {31'b0, bus.stall}, 32'd0);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("idle_stall", {31'b0, bus.stall}, 32'd0);
         chk("idle_ack",   {31'b0, bus.ack},   32'd0);
         chk("idle_rd",    bus.rd, 32'd0);
      end
      @(posedge clk); #1;

      // Directed table: timing, read-after-write, back-to-back, wrap
      tbl.push_back('{1'b1, 32'h40,  32'hDEADBEEF, 4'hF, 32'h0});
      tbl.push_back('{1'b0, 32'h40,  32'h0,        4'hF, 32'hDEADBEEF});
      tbl.push_back('{1'b1, 32'h10,  32'h5,        4'hF, 32'hDEADBEEF});
      tbl.push_back('{1'b0, 32'h10,  32'h0,        4'hF, 32'h5});
      tbl.push_back('{1'b1, 32'h100, 32'h11,       4'hF, 32'h5});
      tbl.push_back('{1'b0, 32'h000, 32'h0,        4'hF, 32'h11});
      tbl.push_back('{1'b1, 32'h20,  32'h55,       4'hF, 32'h11});
      tbl.push_back('{1'b0, 32'h20,  32'h0,        4'hF, 32'h55});
`ifdef DMEM_BYTE_WRITE_EN
      tbl.push_back('{1'b1, 32'h30,  32'h11223344, 4'hF, 32'h55});
      tbl.push_back('{1'b1, 32'h30,  32'hAABBCCDD, 4'h5, 32'h55});
      tbl.push_back('{1'b0, 32'h30,  32'h0,        4'hF, 32'h11BB33DD});
      tbl.push_back('{1'b1, 32'h34,  32'hCAFEF00D, 4'hF, 32'h11BB33DD});
      tbl.push_back('{1'b1, 32'h34,  32'h0,        4'h0, 32'h11BB33DD});
      tbl.push_back('{1'b0, 32'h34,  32'h0,        4'hF, 32'hCAFEF00D});
`endif
      foreach (tbl[i])
         do_op(tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].be, 1'b0, 1'b1, tbl[i].exp);

      // Reset in the last WAIT cycle of a store: store must be dropped
      bus.req = 1'b1; bus.we = 1'b1; bus.a = 32'h20; bus.wd = 32'hAA;
`ifdef DMEM_BYTE_WRITE_EN
      bus.be = 4'hF;
`endif
      for (int c = 0; c < LAT; c++) begin
         @(negedge clk);
         chk("abort_stall_pre", {31'b0, bus.stall}, 32'd1);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("abort_stall_wait", {31'b0, bus.stall}, 32'd1);
      reset = 1'b1; bus.req = 1'b0;
      #1;
      chk("abort_stall_now", {31'b0, bus.stall}, 32'd0);
      chk("abort_rd_now",    bus.rd, 32'd0);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      last_rd = '0;
      @(negedge clk);
      chk("abort_after_stall", {31'b0, bus.stall}, 32'd0);
      chk("abort_after_ack",   {31'b0, bus.ack},   32'd0);
      @(posedge clk); #1;
      do_op(1'b0, 32'h20, 32'h0, 4'hF, 1'b0, 1'b1, 32'h55);

      // req held through DONE is not a new request
      do_op(1'b0, 32'h40, 32'h0, 4'hF, 1'b1, 1'b1, 32'hDEADBEEF);

      // Give every word a known value, then random traffic against the model
      for (int i = 0; i < DEPTH; i++)
         do_op(1'b1, 32'(i * 4), $urandom, 4'hF, 1'b0, 1'b0, 32'h0);
      for (int n = 0; n < 150; n++)
         do_op(1'($urandom), $urandom, $urandom, 4'($urandom),
               ($urandom_range(0, 3) == 0), 1'b0, 32'h0);

      @(negedge clk);
      chk("final_ack",   {31'b0, bus.ack},   32'd0);
      chk("final_stall", {31'b0, bus.stall}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
